// File: rtl/msg_disasm.sv
// msg_disasm: pops FIFO packets and serialises them word 0 first into a valid/ready UART stream.
// Optional `define MSG_DISASM_GAP_EN inserts GAP_CYCLES idle cycles after every accepted word.
module msg_disasm #(
  parameter int WORD_SIZE        = 8,
  parameter int WORDS_PER_PACKET = 4,
  parameter int CTR_WIDTH        = (WORDS_PER_PACKET > 1) ? $clog2(WORDS_PER_PACKET) : 1,
  parameter int GAP_CYCLES       = 16
) (
  input  logic                                  clk,
  input  logic                                  n_reset,
  input  logic [WORD_SIZE*WORDS_PER_PACKET-1:0] data_in,
  input  logic                                  data_in_valid,
  output logic                                  data_in_ready,
  output logic [WORD_SIZE-1:0]                  data_out,
  output logic                                  data_out_valid,
  input  logic                                  data_out_ready,
  output logic                                  busy
);
  localparam int INPUT_WIDTH = WORD_SIZE*WORDS_PER_PACKET;
  localparam logic [CTR_WIDTH-1:0] CTR_LAST = CTR_WIDTH'(WORDS_PER_PACKET-1);
`ifdef MSG_DISASM_GAP_EN
  typedef enum logic [1:0] {SM_IDLE, SM_SEND, SM_GAP} state_t;
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES+1) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES-1 : 0);
  logic [GW-1:0] gap, gap_nxt;
`else
  typedef enum logic [1:0] {SM_IDLE, SM_SEND} state_t;
`endif
  state_t state, state_nxt, st_adv;
  logic [INPUT_WIDTH-1:0] sreg, sreg_nxt;
  logic [CTR_WIDTH-1:0] ctr, ctr_nxt, ctr_adv;
  logic last;
  assign last = ctr == CTR_LAST;
  assign ctr_adv = last ? '0 : ctr + 1'b1;
  assign st_adv = last ? SM_IDLE : SM_SEND;
  assign data_in_ready = n_reset && state == SM_IDLE;
  assign data_out_valid = state == SM_SEND;
  assign busy = state != SM_IDLE;
  assign data_out = sreg[WORD_SIZE-1:0];
  always_comb begin
    state_nxt = state;
    sreg_nxt = sreg;
    ctr_nxt = ctr;
`ifdef MSG_DISASM_GAP_EN
    gap_nxt = gap;
`endif
    case (state)
      SM_IDLE: if (data_in_valid) begin
        sreg_nxt = data_in;
        ctr_nxt = '0;
        state_nxt = SM_SEND;
      end
      SM_SEND: if (data_out_ready) begin
        sreg_nxt = sreg >> WORD_SIZE;
`ifdef MSG_DISASM_GAP_EN
        if (GAP_CYCLES > 0) begin
          gap_nxt = '0;
          state_nxt = SM_GAP;
        end else begin
          ctr_nxt = ctr_adv;
          state_nxt = st_adv;
        end
`else
        ctr_nxt = ctr_adv;
        state_nxt = st_adv;
`endif
      end
`ifdef MSG_DISASM_GAP_EN
      SM_GAP: if (gap == GAP_LAST) begin
        ctr_nxt = ctr_adv;
        state_nxt = st_adv;
      end else gap_nxt = gap + 1'b1;
`endif
      default: state_nxt = SM_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      state <= SM_IDLE;
      sreg <= '0;
      ctr <= '0;
`ifdef MSG_DISASM_GAP_EN
      gap <= '0;
`endif
    end else begin
      state <= state_nxt;
      sreg <= sreg_nxt;
      ctr <= ctr_nxt;
`ifdef MSG_DISASM_GAP_EN
      gap <= gap_nxt;
`endif
    end
endmodule

// File: tb/tb_msg_disasm.sv
// tb_msg_disasm: checks a 4-word and a 1-word disassembler against a packet/word-count reference model.
module tb_msg_disasm;
`ifdef MSG_DISASM_GAP_EN
  localparam int GAP = 3;
`else
  localparam int GAP = 0;
`endif
  logic clk = 1'b0;
  logic n_reset = 1'b0;
  logic iv [2];
  logic ir [2];
  logic ov [2];
  logic ordy [2];
  logic bz [2];
  logic [31:0] din [2];
  logic [7:0] dout [2];
  int wl [2];
  int gl [2];
  int np [2];
  logic [31:0] pk [2];
  logic [31:0] f0 [$];
  logic [31:0] f1 [$];
  logic [7:0] got [$];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  msg_disasm #(.WORD_SIZE(8), .WORDS_PER_PACKET(4), .GAP_CYCLES(3)) u_dut4 (
    .clk(clk), .n_reset(n_reset), .data_in(din[0]), .data_in_valid(iv[0]),
    .data_in_ready(ir[0]), .data_out(dout[0]), .data_out_valid(ov[0]),
    .data_out_ready(ordy[0]), .busy(bz[0])
  );
  msg_disasm #(.WORD_SIZE(8), .WORDS_PER_PACKET(1), .GAP_CYCLES(3)) u_dut1 (
    .clk(clk), .n_reset(n_reset), .data_in(din[1][7:0]), .data_in_valid(iv[1]),
    .data_in_ready(ir[1]), .data_out(dout[1]), .data_out_valid(ov[1]),
    .data_out_ready(ordy[1]), .busy(bz[1])
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // One clock: check outputs against the model, advance the model, cross the rising edge.
  task automatic tick();
    logic idle, re, ve;
    iv[0] = f0.size() > 0;
    din[0] = iv[0] ? f0[0] : $urandom;
    iv[1] = f1.size() > 0;
    din[1] = iv[1] ? f1[0] : $urandom;
    #1;
    for (int i = 0; i < 2; i++) begin
      idle = wl[i] == 0 && gl[i] == 0;
      re = n_reset && idle;
      ve = wl[i] > 0 && gl[i] == 0;
      check($sformatf("ready%0d", i), ir[i], re);
      check($sformatf("valid%0d", i), ov[i], ve);
      check($sformatf("busy%0d", i), bz[i], !idle);
      if (ve) check($sformatf("data%0d", i), dout[i], (pk[i] >> (8*(np[i]-wl[i]))) & 32'hFF);
      if (re && iv[i]) begin
        pk[i] = din[i];
        wl[i] = np[i];
        if (i == 0) void'(f0.pop_front());
        else void'(f1.pop_front());
      end else if (ve && ordy[i]) begin
        if (i == 0) got.push_back(dout[i]);
        wl[i]--;
        gl[i] = GAP;
      end else if (gl[i] > 0) gl[i]--;
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic drain();
    repeat (12 + 10*GAP) tick();
  endtask
  task automatic expect_words(input string tag, input logic [63:0] exp, input int n);
    check({tag, "_count"}, got.size(), n);
    for (int k = 0; k < n && k < got.size(); k++)
      check($sformatf("%s_w%0d", tag, k), got[k], exp[8*k +: 8]);
    got.delete();
  endtask
  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_ready%0d", tag, i), ir[i], 1'b0);
      check($sformatf("%s_valid%0d", tag, i), ov[i], 1'b0);
      check($sformatf("%s_busy%0d", tag, i), bz[i], 1'b0);
      check($sformatf("%s_data%0d", tag, i), dout[i], 8'h00);
    end
  endtask
  initial begin
    np[0] = 4;
    np[1] = 1;
    for (int i = 0; i < 2; i++) begin
      wl[i] = 0;
      gl[i] = 0;
      pk[i] = '0;
      iv[i] = 1'b1;
      ordy[i] = 1'b1;
      din[i] = $urandom;
    end
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    n_reset = 1'b1;
    f0.push_back(32'h44332211);
    f1.push_back(32'h5A);
    drain();
    expect_words("basic", 64'h44332211, 4);
    f0.push_back(32'h44332211);
    tick();
    tick();
    tick();
    ordy[0] = 1'b0;
    repeat (5) tick();
    ordy[0] = 1'b1;
    drain();
    expect_words("backpressure", 64'h44332211, 4);
    f0.push_back(32'hDDCCBBAA);
    f0.push_back(32'h04030201);
    f1.push_back(32'h5A);
    f1.push_back(32'hA5);
    f1.push_back(32'h3C);
    f1.push_back(32'hC3);
    drain();
    expect_words("b2b", 64'h04030201DDCCBBAA, 8);
    repeat (300) begin
      if (f0.size() < 2 && $urandom_range(0, 3) == 0) f0.push_back($urandom);
      if (f1.size() < 2 && $urandom_range(0, 2) == 0) f1.push_back($urandom);
      ordy[0] = $urandom_range(0, 3) != 0;
      ordy[1] = $urandom_range(0, 3) != 0;
      tick();
    end
    ordy[0] = 1'b1;
    ordy[1] = 1'b1;
    drain();
    got.delete();
    f0.push_back(32'h88776655);
    f1.push_back(32'h77);
    tick();
    tick();
    tick();
    #2;
    n_reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    for (int i = 0; i < 2; i++) begin
      wl[i] = 0;
      gl[i] = 0;
    end
    f0.delete();
    f1.delete();
    got.delete();
    @(negedge clk);
    n_reset = 1'b1;
    f0.push_back(32'h44332211);
    f1.push_back(32'h5A);
    drain();
    expect_words("after_reset", 64'h44332211, 4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
